// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin-change ejector. On an accepted start it pays
// amt cents as a sequence of one-cycle coin strobes separated by one idle
// cycle, largest coin first, then pulses done and reports any unpaid rest.
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  synchronous active-high reset
//   start  in   1  one-cycle request, accepted only when idle
//   amt    in   8  change amount in cents, sampled on accepted start
//   c      out  1  coin-eject strobe, one cycle per coin
//   a      out  8  value of coin being ejected while c=1, else 0
//   busy   out  1  high from accepted start through the done cycle
//   done   out  1  one-cycle completion pulse
//   err    out  1  unpaid remainder, valid from done until next start
//   coins  out  4  coins ejected in the current/last transaction
//
// Build option: define CHANGE_PENNY_EN to add the 1-cent coin
// (coin set {25,10,5,1}); otherwise the set is {25,10,5}.
module change_dispenser (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] amt,
   output logic       c,
   output logic [7:0] a,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [3:0] coins
);

`ifdef CHANGE_PENNY_EN
   localparam logic [7:0] MIN_COIN = 8'd1;
`else
   localparam logic [7:0] MIN_COIN = 8'd5;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_EJECT,
      S_GAP,
      S_DONE
   } state_t;

   state_t     r_state;
   logic [7:0] r_rem;

   // Amount still owed as seen by the coin picker: the new request while
   // idle, otherwise the running remainder (already reduced in GAP).
   logic [7:0] w_src;
   logic [7:0] w_coin;

   always_comb begin
      w_src = (r_state == S_IDLE) ? amt : r_rem;
   end

   // Largest coin not exceeding the amount owed; 0 when none fits.
   always_comb begin
      w_coin = 8'd0;
      if (w_src >= 8'd25) begin
         w_coin = 8'd25;
      end else if (w_src >= 8'd10) begin
         w_coin = 8'd10;
      end else if (w_src >= 8'd5) begin
         w_coin = 8'd5;
`ifdef CHANGE_PENNY_EN
      end else if (w_src >= 8'd1) begin
         w_coin = 8'd1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rem   <= 8'd0;
         c       <= 1'b0;
         a       <= 8'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         coins   <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               c    <= 1'b0;
               a    <= 8'd0;
               busy <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  r_rem <= amt;
                  coins <= 4'd0;
                  err   <= 1'b0;
                  busy  <= 1'b1;
                  if (amt >= MIN_COIN) begin
                     r_state <= S_EJECT;
                     c       <= 1'b1;
                     a       <= w_coin;
                  end else begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                     err     <= (amt != 8'd0);
                  end
               end
            end
            S_EJECT: begin
               // a holds the coin just ejected; it never exceeds r_rem.
               r_rem   <= r_rem - a;
               coins   <= coins + 4'd1;
               c       <= 1'b0;
               a       <= 8'd0;
               r_state <= S_GAP;
            end
            S_GAP: begin
               if (r_rem >= MIN_COIN) begin
                  r_state <= S_EJECT;
                  c       <= 1'b1;
                  a       <= w_coin;
               end else begin
                  r_state <= S_DONE;
                  done    <= 1'b1;
                  err     <= (r_rem != 8'd0);
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               c       <= 1'b0;
               a       <= 8'd0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench for change_dispenser.
// Expected coins are queued at start and popped on each strobe.
module tb_change_dispenser;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] amt;
   logic       c;
   logic [7:0] a;
   logic       busy;
   logic       done;
   logic       err;
   logic [3:0] coins;

   int vec  = 0;
   int miss = 0;

   logic [7:0] exp_q[$];
   logic       exp_err;

   change_dispenser dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .amt   (amt),
      .c     (c),
      .a     (a),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .coins (coins)
   );

   always #5 clk = ~clk;

   // Reference greedy payout, filling the scoreboard.
   function automatic void model(input logic [7:0] v);
      logic [7:0] r;
      logic [7:0] k;
      r = v;
      forever begin
         if (r >= 25) k = 25;
         else if (r >= 10) k = 10;
         else if (r >= 5) k = 5;
`ifdef CHANGE_PENNY_EN
         else if (r >= 1) k = 1;
`endif
         else break;
         exp_q.push_back(k);
         r = r - k;
      end
      exp_err = (r != 0);
   endfunction

   // Runs one transaction; poke_cyc>0 fires a stray start in that cycle.
   task automatic run_txn(input logic [7:0] v, input int poke_cyc,
                          input string nm);
      int n;
      int seen;
      bit fin;
      logic [7:0] e;
      n = exp_q.size();
      seen = 0;
      fin = 0;
      @(negedge clk);
      start = 1'b1;
      amt = v;
      @(posedge clk);
      #1;
      start = 1'b0;
      amt = ~v;
      for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
         @(negedge clk);
         if (cyc == poke_cyc + 1) start = 1'b0;
         if (cyc == poke_cyc) begin
            start = 1'b1;
            amt = 8'd200;
         end
         vec++;
         if (busy !== 1'b1) begin
            miss++;
            $display("FAIL %s busy cyc=%0d got=%b want=1", nm, cyc, busy);
         end
         if (c === 1'b1) begin
            vec++;
            if (exp_q.size() == 0) begin
               miss++;
               $display("FAIL %s extra strobe cyc=%0d a=%0d", nm, cyc, a);
            end else begin
               e = exp_q.pop_front();
               if (a !== e) begin
                  miss++;
                  $display("FAIL %s coin%0d got=%0d want=%0d",
                           nm, seen, a, e);
               end
               vec++;
               if (cyc != 2 * seen + 1) begin
                  miss++;
                  $display("FAIL %s strobe%0d cyc got=%0d want=%0d",
                           nm, seen, cyc, 2 * seen + 1);
               end
            end
            seen++;
         end else begin
            vec++;
            if (a !== 8'd0) begin
               miss++;
               $display("FAIL %s a idle cyc=%0d got=%0d want=0", nm, cyc, a);
            end
         end
         if (done === 1'b1) begin
            fin = 1;
            vec++;
            if (cyc != 2 * n + 1) begin
               miss++;
               $display("FAIL %s done cyc got=%0d want=%0d", nm, cyc,
                        2 * n + 1);
            end
            vec++;
            if (seen != n) begin
               miss++;
               $display("FAIL %s strobes got=%0d want=%0d", nm, seen, n);
            end
            vec++;
            if (err !== exp_err) begin
               miss++;
               $display("FAIL %s err got=%b want=%b", nm, err, exp_err);
            end
            vec++;
            if (coins !== 4'(n)) begin
               miss++;
               $display("FAIL %s coins got=%0d want=%0d", nm, coins, n);
            end
         end
      end
      start = 1'b0;
      if (!fin) begin
         vec++;
         miss++;
         $display("FAIL %s timeout got=no done want=done", nm);
      end
      @(negedge clk);
      vec++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== exp_err) begin
         miss++;
         $display("FAIL %s after done busy/done/err got=%b%b%b want=00%b",
                  nm, busy, done, err, exp_err);
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      amt = 8'd40;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vec++;
      if ({c, a, busy, done, err, coins} !== 15'd0) begin
         miss++;
         $display("FAIL reset outs got=%b%h%b%b%b%h want=0",
                  c, a, busy, done, err, coins);
      end
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      vec++;
      if (busy !== 1'b0 || c !== 1'b0) begin
         miss++;
         $display("FAIL reset idle busy/c got=%b%b want=00", busy, c);
      end
   endtask

   task automatic test_amt40();
      exp_q = '{8'd25, 8'd10, 8'd5};
      exp_err = 1'b0;
      run_txn(8'd40, 0, "amt40");
   endtask

   task automatic test_zero();
      exp_err = 1'b0;
      run_txn(8'd0, 0, "amt0");
   endtask

   task automatic test_odd();
`ifdef CHANGE_PENNY_EN
      exp_q = '{8'd10, 8'd5, 8'd1, 8'd1};
      exp_err = 1'b0;
`else
      exp_q = '{8'd10, 8'd5};
      exp_err = 1'b1;
`endif
      run_txn(8'd17, 0, "amt17");
`ifdef CHANGE_PENNY_EN
      exp_q = '{8'd1, 8'd1, 8'd1};
      exp_err = 1'b0;
`else
      exp_err = 1'b1;
`endif
      run_txn(8'd3, 0, "amt3");
   endtask

   task automatic test_max();
      for (int i = 0; i < 10; i++) exp_q.push_back(8'd25);
      exp_q.push_back(8'd5);
      exp_err = 1'b0;
      run_txn(8'd255, 0, "amt255");
   endtask

   task automatic test_back_to_back();
      exp_q = '{8'd25, 8'd10, 8'd5};
      exp_err = 1'b0;
      run_txn(8'd40, 2, "gap_start_a");
      exp_q = '{8'd25, 8'd10, 8'd5};
      exp_err = 1'b0;
      run_txn(8'd40, 4, "gap_start_b");
   endtask

   task automatic test_random();
      logic [7:0] v;
      for (int i = 0; i < 6; i++) begin
         v = 8'($urandom_range(0, 255));
         model(v);
         run_txn(v, 0, "random");
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start = 1'b1;
      amt = 8'd40;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      vec++;
      if (c !== 1'b1 || a !== 8'd25) begin
         miss++;
         $display("FAIL rstmid first strobe got=%b/%0d want=1/25", c, a);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         vec++;
         if (c !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
             coins !== 4'd0) begin
            miss++;
            $display("FAIL rstmid cyc%0d c/busy/done/coins got=%b%b%b/%0d want=000/0",
                     i, c, busy, done, coins);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      amt = 8'd0;
      exp_err = 1'b0;
      test_reset();
      test_amt40();
      test_zero();
      test_odd();
      test_max();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
